// File: rtl/nes_pad_reader.sv
// NES game-pad poller: drives latch/clock strobes, shifts in the 8 buttons and turns
// button edges, auto-repeat and held Down into one-cycle Tetris move commands.
module nes_pad_reader #(
  parameter int unsigned POLL_CYCLES      = 833333,
  parameter int unsigned LATCH_CYCLES     = 600,
  parameter int unsigned HALF_BIT_CYCLES  = 300,
  parameter int unsigned DAS_POLLS        = 10,
  parameter int unsigned ARR_POLLS        = 3,
  parameter int unsigned RESET_HOLD_POLLS = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       nes_in,
  output logic       nes_latch,
  output logic       nes_clk,
  output logic [3:0] button_data_out,
  output logic [7:0] buttons_raw,
  output logic       nes_reset
);

  localparam int unsigned PollW = $clog2(POLL_CYCLES);
  localparam int unsigned PhMax = (LATCH_CYCLES > HALF_BIT_CYCLES) ? LATCH_CYCLES
                                                                  : HALF_BIT_CYCLES;
  localparam int unsigned PhW   = $clog2(PhMax + 1);
  localparam int unsigned DasW  = $clog2(DAS_POLLS + ARR_POLLS + 1);
  localparam int unsigned HoldW = $clog2(RESET_HOLD_POLLS + 1);

  localparam logic [3:0] CmdNone     = 4'd0;
  localparam logic [3:0] CmdLeft     = 4'd1;
  localparam logic [3:0] CmdRight    = 4'd2;
  localparam logic [3:0] CmdDown     = 4'd3;
  localparam logic [3:0] CmdRotCw    = 4'd4;
  localparam logic [3:0] CmdRotCcw   = 4'd5;
  localparam logic [3:0] CmdHardDrop = 4'd6;
  localparam logic [3:0] CmdPause    = 4'd7;

  typedef enum logic [2:0] {
    StIdle, StLatch, StGap, StHigh, StLow, StDecode, StEmit
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         sync_q;
  logic [PollW-1:0]   poll_q;
  logic [PhW-1:0]     ph_q, ph_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         sample_q, sample_d;
  logic [7:0]         raw_q;
  logic [3:0]         cmd_q, cmd_d;
  logic               rst_pulse_q, rst_pulse_d;
  logic [DasW-1:0]    left_cnt_q, left_cnt_d, right_cnt_q, right_cnt_d;
  logic               armed_q, armed_d;
  logic [HoldW-1:0]   hold_q, hold_d;

  logic               poll_wrap, pressed, half_done;
  logic [7:0]         rise;
  logic               both_dirs, left_rep, right_rep, combo;
  logic [HoldW-1:0]   hold_inc;

  assign poll_wrap = (poll_q == PollW'(POLL_CYCLES - 1));
  assign pressed   = ~sync_q[1];
  assign half_done = (ph_q == PhW'(HALF_BIT_CYCLES - 1));

  // Counter clears on a new press or release; after DAS it cycles DAS..DAS+ARR-1.
  function automatic logic [DasW-1:0] das_next(input logic held, input logic fresh,
                                               input logic [DasW-1:0] cnt);
    logic [DasW-1:0] inc;
    inc = cnt + 1'b1;
    if (!held || fresh) begin
      return '0;
    end else if (inc == DasW'(DAS_POLLS + ARR_POLLS)) begin
      return DasW'(DAS_POLLS);
    end
    return inc;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b11;
      poll_q <= '0;
    end else begin
      sync_q <= {sync_q[0], nes_in};
      poll_q <= poll_wrap ? '0 : poll_q + 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    ph_d     = ph_q;
    bit_d    = bit_q;
    sample_d = sample_q;
    unique case (state_q)
      StIdle: begin
        if (poll_wrap) begin
          state_d = StLatch;
          ph_d    = '0;
        end
      end
      StLatch: begin
        if (ph_q == PhW'(LATCH_CYCLES - 1)) begin
          state_d = StGap;
          ph_d    = '0;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      StGap: begin
        if (half_done) begin
          sample_d[0] = pressed;
          bit_d       = 3'd1;
          state_d     = StHigh;
          ph_d        = '0;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      StHigh: begin
        if (half_done) begin
          state_d = StLow;
          ph_d    = '0;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      StLow: begin
        if (half_done) begin
          sample_d[bit_q] = pressed;
          ph_d            = '0;
          if (bit_q == 3'd7) begin
            state_d = StDecode;
          end else begin
            bit_d   = bit_q + 1'b1;
            state_d = StHigh;
          end
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      StDecode: state_d = StEmit;
      StEmit:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      ph_q     <= '0;
      bit_q    <= '0;
      sample_q <= '0;
    end else begin
      state_q  <= state_d;
      ph_q     <= ph_d;
      bit_q    <= bit_d;
      sample_q <= sample_d;
    end
  end

  // Decode: raw_q still holds the previous poll's sample here.
  always_comb begin
    rise        = sample_q & ~raw_q;
    both_dirs   = sample_q[6] & sample_q[7];
    left_cnt_d  = das_next(sample_q[6], rise[6], left_cnt_q);
    right_cnt_d = das_next(sample_q[7], rise[7], right_cnt_q);
    left_rep    = sample_q[6] && !rise[6] && !both_dirs && (left_cnt_d == DasW'(DAS_POLLS));
    right_rep   = sample_q[7] && !rise[7] && !both_dirs && (right_cnt_d == DasW'(DAS_POLLS));

    cmd_d = CmdNone;
    if (rise[0])                       cmd_d = CmdRotCw;
    else if (rise[1])                  cmd_d = CmdRotCcw;
    else if (rise[4])                  cmd_d = CmdHardDrop;
    else if (rise[6])                  cmd_d = CmdLeft;
    else if (rise[7])                  cmd_d = CmdRight;
    else if (rise[3] && !sample_q[2])  cmd_d = CmdPause;
    else if (left_rep)                 cmd_d = CmdLeft;
    else if (right_rep)                cmd_d = CmdRight;
    else if (sample_q[5])              cmd_d = CmdDown;

    combo       = sample_q[2] & sample_q[3];
    hold_inc    = hold_q + 1'b1;
    armed_d     = armed_q;
    hold_d      = '0;
    rst_pulse_d = 1'b0;
    if (!combo) begin
      armed_d = 1'b1;
    end else if (armed_q) begin
      if (hold_inc == HoldW'(RESET_HOLD_POLLS)) begin
        rst_pulse_d = 1'b1;
        armed_d     = 1'b0;
      end else begin
        hold_d = hold_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      raw_q       <= '0;
      cmd_q       <= CmdNone;
      rst_pulse_q <= 1'b0;
      left_cnt_q  <= '0;
      right_cnt_q <= '0;
      armed_q     <= 1'b0;
      hold_q      <= '0;
    end else if (state_q == StDecode) begin
      raw_q       <= sample_q;
      cmd_q       <= cmd_d;
      rst_pulse_q <= rst_pulse_d;
      left_cnt_q  <= left_cnt_d;
      right_cnt_q <= right_cnt_d;
      armed_q     <= armed_d;
      hold_q      <= hold_d;
    end
  end

  assign nes_latch       = (state_q == StLatch);
  assign nes_clk         = (state_q == StHigh);
  assign button_data_out = (state_q == StEmit) ? cmd_q : CmdNone;
  assign nes_reset       = (state_q == StEmit) && rst_pulse_q;
  assign buttons_raw     = raw_q;

endmodule

// File: tb/tb_nes_pad_reader.sv
// Bench for nes_pad_reader: models the pad's parallel-load shift register and scores
// each poll's command, reset pulse, strobe shape and sampled buttons against a queue.
module tb_nes_pad_reader;

  localparam int unsigned POLL  = 2000;
  localparam int unsigned LATCH = 4;
  localparam int unsigned HALF  = 2;
  localparam int unsigned EMIT_OFF = LATCH + HALF + 14 * HALF + 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       nes_in;
  logic       nes_latch, nes_clk, nes_reset;
  logic [3:0] button_data_out;
  logic [7:0] buttons_raw;

  logic [7:0] pad_buttons = 8'h00;
  logic [7:0] pad_sr = 8'h00;

  typedef struct {
    logic [7:0] pad;
    logic [3:0] code;
    logic       rst;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int failures = 0;
  int poll_idx = 0;
  int waited;

  nes_pad_reader #(
    .POLL_CYCLES(POLL), .LATCH_CYCLES(LATCH), .HALF_BIT_CYCLES(HALF),
    .DAS_POLLS(3), .ARR_POLLS(2), .RESET_HOLD_POLLS(4)
  ) dut (
    .clk(clk), .reset(reset), .nes_in(nes_in), .nes_latch(nes_latch), .nes_clk(nes_clk),
    .button_data_out(button_data_out), .buttons_raw(buttons_raw), .nes_reset(nes_reset)
  );

  always #5 clk = ~clk;

  // Pad: loads on latch, shifts toward bit0 on each rising nes_clk, data active-low.
  always @(posedge nes_latch or posedge nes_clk) begin
    if (nes_latch) pad_sr <= pad_buttons;
    else           pad_sr <= {1'b0, pad_sr[7:1]};
  end
  assign nes_in = ~pad_sr[0];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic do_poll(input logic [7:0] pad, input logic [3:0] code, input logic rst_exp,
                         output int wait_n);
    int n = 0;
    int latch_cyc = 0, clk_high = 0, clk_rise = 0;
    int cmd_cnt = 0, cmd_off = -1, rst_cnt = 0, rst_off = -1;
    logic [3:0] cmd_val = 4'd0;
    logic clk_prev = 1'b0;
    exp_t e;
    poll_idx++;
    pad_buttons = pad;
    exp_q.push_back('{pad: pad, code: code, rst: rst_exp});
    while (nes_latch !== 1'b1 && n < int'(POLL) + 50) begin
      @(negedge clk);
      n++;
    end
    wait_n = n;
    e = exp_q.pop_front();
    if (nes_latch !== 1'b1) begin
      check_eq($sformatf("p%0d_latch_timeout", poll_idx), 32'd0, 32'd1);
      return;
    end
    for (int off = 0; off < 40; off++) begin
      if (nes_latch) latch_cyc++;
      if (nes_clk) clk_high++;
      if (nes_clk && !clk_prev) clk_rise++;
      clk_prev = nes_clk;
      if (button_data_out != 4'd0) begin
        if (cmd_cnt == 0) begin
          cmd_val = button_data_out;
          cmd_off = off;
        end
        cmd_cnt++;
      end
      if (nes_reset) begin
        if (rst_cnt == 0) rst_off = off;
        rst_cnt++;
      end
      @(negedge clk);
    end
    check_eq($sformatf("p%0d_latch_cycles", poll_idx), latch_cyc, LATCH);
    check_eq($sformatf("p%0d_clk_pulses", poll_idx), clk_rise, 7);
    check_eq($sformatf("p%0d_clk_high", poll_idx), clk_high, 7 * HALF);
    check_eq($sformatf("p%0d_code", poll_idx), cmd_val, e.code);
    check_eq($sformatf("p%0d_code_cycles", poll_idx), cmd_cnt, (e.code != 4'd0) ? 1 : 0);
    if (e.code != 4'd0) check_eq($sformatf("p%0d_code_latency", poll_idx), cmd_off, EMIT_OFF);
    check_eq($sformatf("p%0d_nes_reset_cycles", poll_idx), rst_cnt, e.rst ? 1 : 0);
    if (e.rst) check_eq($sformatf("p%0d_nes_reset_latency", poll_idx), rst_off, EMIT_OFF);
    check_eq($sformatf("p%0d_buttons_raw", poll_idx), buttons_raw, e.pad);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] t3_code [9];
    logic [3:0] t4_code [5];
    int n;
    t3_code = '{4'd1, 4'd0, 4'd0, 4'd1, 4'd0, 4'd1, 4'd0, 4'd1, 4'd0};
    t4_code = '{4'd4, 4'd3, 4'd3, 4'd1, 4'd3};

    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_latch", nes_latch, 0);
    check_eq("rst_clk", nes_clk, 0);
    check_eq("rst_code", button_data_out, 0);
    check_eq("rst_raw", buttons_raw, 0);
    check_eq("rst_nes_reset", nes_reset, 0);
    @(negedge clk);
    reset = 1'b0;

    // Idle pad, then A pressed and held.
    do_poll(8'h00, 4'd0, 1'b0, waited);
    do_poll(8'h01, 4'd4, 1'b0, waited);
    for (int i = 0; i < 4; i++) do_poll(8'h01, 4'd0, 1'b0, waited);

    // Left held for 8 polls with DAS=3/ARR=2, then released.
    for (int i = 0; i < 9; i++) do_poll((i < 8) ? 8'h40 : 8'h00, t3_code[i], 1'b0, waited);

    // A + Left + Down together, kept held.
    for (int i = 0; i < 5; i++) do_poll(8'h61, t4_code[i], 1'b0, waited);

    // Start alone pauses; Left+Right edge picks Left, then no repeat while both held.
    do_poll(8'h08, 4'd7, 1'b0, waited);
    do_poll(8'hC0, 4'd1, 1'b0, waited);
    for (int i = 0; i < 3; i++) do_poll(8'hC0, 4'd0, 1'b0, waited);
    do_poll(8'h16, 4'd5, 1'b0, waited);
    do_poll(8'h80, 4'd2, 1'b0, waited);
    do_poll(8'hA5, 4'd4, 1'b0, waited);

    // Select+Start held straight out of reset, released, then re-held.
    pulse_reset();
    do_poll(8'h0C, 4'd0, 1'b0, waited);
    do_poll(8'h0C, 4'd0, 1'b0, waited);
    do_poll(8'h00, 4'd0, 1'b0, waited);
    do_poll(8'h0C, 4'd0, 1'b0, waited);
    do_poll(8'h0C, 4'd0, 1'b0, waited);
    do_poll(8'h0C, 4'd0, 1'b0, waited);
    do_poll(8'h0C, 4'd0, 1'b1, waited);
    do_poll(8'h0C, 4'd0, 1'b0, waited);

    // Reset in the HIGH phase of bit 4 aborts the read.
    pad_buttons = 8'h01;
    n = 0;
    while (nes_latch !== 1'b1 && n < int'(POLL) + 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("t6_latch_seen", nes_latch, 1);
    repeat (LATCH + HALF + 3 * 2 * HALF) @(negedge clk);
    check_eq("t6_clk_before", nes_clk, 1);
    reset = 1'b1;
    #1;
    check_eq("t6_clk_abort", nes_clk, 0);
    check_eq("t6_latch_abort", nes_latch, 0);
    check_eq("t6_code_abort", button_data_out, 0);
    @(negedge clk);
    reset = 1'b0;
    do_poll(8'h01, 4'd4, 1'b0, waited);
    check_eq("t6_restart_wait", waited, POLL);

    check_eq("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
